// File: rtl/uart_mem_loader.sv
// Packs a received UART byte stream little-endian into 32-bit words and writes
// them sequentially through a stall-capable memory port, holding the CPU meanwhile.
module uart_mem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 16384,
    parameter logic [15:0] IDLE_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        loading,
    output logic        done,
    output logic        overflow,
    output logic [14:0] word_count
);

    // state   | meaning
    // S_IDLE  | waiting for the first byte, CPU not held
    // S_LOAD  | packing bytes into words, CPU held
    // S_FLUSH | issuing any partial word and draining the write slot
    // S_DONE  | load finished, everything ignored until reset
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] asm_word;
    logic [15:0] idle_cnt;

    logic        accept;
    logic        slot_free;
    logic [15:0] committed;
    logic        at_limit;
    logic        take_byte;
    logic        word_done;
    logic        flush_issue;
    logic        issue;
    logic [31:0] full_word;
    logic [31:0] issue_word;

    assign accept      = mem_we & mem_ready;
    assign slot_free   = ~mem_we | accept;
    // Words already accepted plus the one in the slot; once this hits the
    // limit no further word may be formed, so no write lands past the limit.
    assign committed   = {1'b0, word_count} + {15'd0, mem_we};
    assign at_limit    = committed >= MAX_W;
    assign take_byte   = (state == S_LOAD) && byte_valid && !at_limit;
    assign full_word   = {byte_in, asm_word[23:0]};
    assign word_done   = take_byte && (idx == 2'd3);
    assign flush_issue = (state == S_FLUSH) && (idx != 2'd0) && slot_free;
    assign issue       = (word_done && slot_free) || flush_issue;
    assign issue_word  = word_done ? full_word : asm_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            asm_word   <= 32'd0;
            idle_cnt   <= 16'd0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
            loading    <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= 15'd0;
        end else begin
            if (accept) begin
                word_count <= word_count + 15'd1;
                mem_addr   <= mem_addr + 32'd4;
            end
            if (issue) begin
                mem_we    <= 1'b1;
                mem_wdata <= issue_word;
            end else if (accept) begin
                mem_we <= 1'b0;
            end
            if (word_done && !slot_free)
                overflow <= 1'b1;

            case (state)
                S_IDLE: begin
                    idle_cnt <= 16'd0;
                    if (byte_valid) begin
                        asm_word <= {24'd0, byte_in};
                        idx      <= 2'd1;
                        loading  <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (take_byte) begin
                        if (idx == 2'd3)
                            asm_word <= 32'd0;
                        else
                            asm_word[{idx, 3'b000} +: 8] <= byte_in;
                        idx <= idx + 2'd1;
                    end
                    if (byte_valid)
                        idle_cnt <= 16'd0;
                    else if (idle_cnt != IDLE_CYCLES)
                        idle_cnt <= idle_cnt + 16'd1;
                    if (idle_cnt == IDLE_CYCLES || {1'b0, word_count} >= MAX_W)
                        state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (flush_issue) begin
                        idx      <= 2'd0;
                        asm_word <= 32'd0;
                    end else if (idx == 2'd0 && !mem_we) begin
                        loading <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed and randomized checks of uart_mem_loader against a byte-packing
// reference model; instance b exercises a tiny word limit.
module tb_uart_mem_loader;

    localparam logic [31:0] BASE_A = 32'h0000_0100;
    localparam logic [15:0] IDLE_A = 16'd100;
    localparam int          MAX_A  = 16384;
    localparam int          MAX_B  = 2;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in, b_byte_in;
    logic        byte_valid, b_byte_valid;
    logic        ready_fix, rand_mode, rr;
    logic        mem_ready;
    logic        b_mem_ready;

    logic        a_mem_we, a_loading, a_done, a_overflow;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [14:0] a_word_count;
    logic        b_mem_we, b_loading, b_done, b_overflow;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [14:0] b_word_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  sent_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] a_wa[$], a_wd[$], b_wa[$], b_wd[$];

    assign mem_ready   = rand_mode ? rr : ready_fix;
    assign b_mem_ready = 1'b1;

    uart_mem_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAX_A), .IDLE_CYCLES(IDLE_A)) dut_a (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_ready(mem_ready), .loading(a_loading), .done(a_done),
        .overflow(a_overflow), .word_count(a_word_count));

    uart_mem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(MAX_B), .IDLE_CYCLES(IDLE_A)) dut_b (
        .clk(clk), .rst(rst), .byte_in(b_byte_in), .byte_valid(b_byte_valid),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ready(b_mem_ready), .loading(b_loading), .done(b_done),
        .overflow(b_overflow), .word_count(b_word_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) rr <= 1'($urandom_range(0, 1));

    // Memory-side view: record every accepted write
    always @(posedge clk) begin
        if (!rst && a_mem_we && mem_ready) begin
            a_wa.push_back(a_mem_addr);
            a_wd.push_back(a_mem_wdata);
        end
        if (!rst && b_mem_we && b_mem_ready) begin
            b_wa.push_back(b_mem_addr);
            b_wd.push_back(b_mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sent_q.delete();
        a_wa.delete(); a_wd.delete(); b_wa.delete(); b_wd.delete();
    endtask

    task automatic send_a(input logic [7:0] b, input int gap);
        byte_in    = b;
        byte_valid = 1'b1;
        sent_q.push_back(b);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        while (!a_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(a_done), 32'd1);
    endtask

    // Little-endian packing of everything sent, zero-padded, capped at maxw words
    task automatic model(input int maxw);
        int nw;
        logic [31:0] w;
        exp_q.delete();
        nw = (sent_q.size() + 3) / 4;
        if (nw > maxw) nw = maxw;
        for (int i = 0; i < nw; i++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++)
                if (4 * i + k < sent_q.size())
                    w = w | (32'(sent_q[4 * i + k]) << (8 * k));
            exp_q.push_back(w);
        end
    endtask

    task automatic compare_a(input string tag);
        check({tag, "_nwrites"}, 32'(a_wa.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < a_wa.size(); i++) begin
            check({tag, "_addr"}, a_wa[i], BASE_A + 32'(4 * i));
            check({tag, "_data"}, a_wd[i], exp_q[i]);
        end
        check({tag, "_count"}, 32'(a_word_count), 32'(exp_q.size()));
    endtask

    initial begin
        int n;
        logic ok;
        logic [31:0] s_addr, s_data;
        logic [7:0] bytes1[8];

        rst = 1'b1; byte_in = 8'd0; byte_valid = 1'b0;
        b_byte_in = 8'd0; b_byte_valid = 1'b0;
        ready_fix = 1'b1; rand_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_we", 32'(a_mem_we), 32'd0);
        check("rst_addr", a_mem_addr, BASE_A);
        check("rst_wdata", a_mem_wdata, 32'd0);
        check("rst_flags", {29'd0, a_loading, a_done, a_overflow}, 32'd0);
        check("rst_count", 32'(a_word_count), 32'd0);

        // No timeout without a first byte
        repeat (150) @(negedge clk);
        check("idle_no_timeout", {30'd0, a_done, a_loading}, 32'd0);

        // Basic load: two words at 20-cycle spacing
        bytes1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) begin
            send_a(bytes1[i], 0);
            if (i == 0) check("loading_high", 32'(a_loading), 32'd1);
            if (i == 2 || i == 6) check("we_before_word", 32'(a_mem_we), 32'd0);
            if (i == 3 || i == 7) begin
                check("we_after_word", 32'(a_mem_we), 32'd1);
                check("wdata_after_word", a_mem_wdata, i == 3 ? 32'h4433_2211 : 32'h8877_6655);
            end
            if (i < 7) repeat (19) @(negedge clk);
        end
        wait_done_a(n);
        check("done_latency", 32'(n >= int'(IDLE_A) && n <= int'(IDLE_A) + 4), 32'd1);
        model(MAX_A);
        compare_a("basic");
        check("basic_ovf", 32'(a_overflow), 32'd0);
        check("basic_loading", 32'(a_loading), 32'd0);

        // Partial last word is zero-padded on flush
        do_reset();
        send_a(8'hAA, 4); send_a(8'hBB, 4); send_a(8'hCC, 4);
        send_a(8'hDD, 4); send_a(8'hEE, 4);
        wait_done_a(n);
        model(MAX_A);
        compare_a("partial");

        // Stall: write held stable while mem_ready low
        do_reset();
        ready_fix = 1'b0;
        send_a(8'h01, 1); send_a(8'h02, 1); send_a(8'h03, 1); send_a(8'h04, 0);
        s_addr = a_mem_addr; s_data = a_mem_wdata;
        check("stall_we", 32'(a_mem_we), 32'd1);
        check("stall_data", s_data, 32'h0403_0201);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ok &= (a_mem_we === 1'b1) && (a_mem_addr === s_addr) && (a_mem_wdata === s_data);
        end
        check("stall_stable", 32'(ok), 32'd1);
        check("stall_count_hold", 32'(a_word_count), 32'd0);
        ready_fix = 1'b1;
        @(negedge clk);
        check("stall_accept_count", 32'(a_word_count), 32'd1);
        check("stall_accept_we", 32'(a_mem_we), 32'd0);
        check("stall_accept_addr", a_mem_addr, BASE_A + 32'd4);
        wait_done_a(n);
        model(MAX_A);
        compare_a("stall");

        // Overflow: second word dropped while slot busy
        do_reset();
        ready_fix = 1'b0;
        for (int i = 0; i < 8; i++) send_a(8'(8'h30 + i), 1);
        check("ovf_flag", 32'(a_overflow), 32'd1);
        check("ovf_wdata_kept", a_mem_wdata, 32'h3332_3130);
        ready_fix = 1'b1;
        wait_done_a(n);
        model(1);
        compare_a("ovf");
        check("ovf_sticky", 32'(a_overflow), 32'd1);

        // Word limit on instance b: 12 back-to-back bytes, only 2 words written
        do_reset();
        for (int i = 0; i < 12; i++) begin
            b_byte_in    = 8'(8'hA0 + i);
            b_byte_valid = 1'b1;
            sent_q.push_back(b_byte_in);
            @(negedge clk);
        end
        b_byte_valid = 1'b0;
        n = 0;
        while (!b_done && n < 1000) begin @(negedge clk); n++; end
        check("lim_done", 32'(b_done), 32'd1);
        model(MAX_B);
        check("lim_nwrites", 32'(b_wa.size()), 32'd2);
        for (int i = 0; i < 2 && i < b_wa.size(); i++) begin
            check("lim_addr", b_wa[i], 32'(4 * i));
            check("lim_data", b_wd[i], exp_q[i]);
        end
        check("lim_count", 32'(b_word_count), 32'd2);
        repeat (20) @(negedge clk);
        check("lim_no_more", 32'(b_wa.size()), 32'd2);

        // Reset mid-load discards partial bytes
        do_reset();
        for (int i = 0; i < 6; i++) send_a(8'(8'h50 + i), 2);
        do_reset();
        check("mid_rst_addr", a_mem_addr, BASE_A);
        check("mid_rst_state", {27'd0, a_mem_we, a_loading, a_done, a_overflow, |a_word_count}, 32'd0);
        for (int i = 0; i < 4; i++) send_a(8'(8'hC0 + i), 2);
        wait_done_a(n);
        model(MAX_A);
        compare_a("mid_rst");
        check("mid_rst_word", a_wd.size() > 0 ? a_wd[0] : 32'hDEAD_BEEF, 32'hC3C2_C1C0);

        // Randomized loads, alternating fixed and random mem_ready
        for (int it = 0; it < 4; it++) begin
            rand_mode = 1'(it % 2);
            do_reset();
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++)
                send_a(8'($urandom_range(0, 255)), $urandom_range(12, 40));
            wait_done_a(n);
            model(MAX_A);
            compare_a("rand");
            check("rand_ovf", 32'(a_overflow), 32'd0);
        end
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
